// File: rtl/hdma_xfer.sv
// hdma_xfer
//   Responder-side byte mover for the GBC HDMA/GDMA controller. Every new
//   source/target address pair presented with the read strobe high is
//   turned into one memory-bus read followed by one VRAM write into the
//   VRAM bank selected at request time. One request can be queued while a
//   byte is in flight; a request that finds the queue full is dropped and
//   flagged on the sticky overflow output. Also produces the CPU stall.
//
// Parameters
//   READ_LAT          memory read latency in clocks (1..3); mem_din is valid
//                     on the last cycle of mem_rd
// Ports
//   clk               8 MHz cpu clock
//   reset             asynchronous active-high reset
//   hdma_rd           controller read strobe; requests valid only while high
//   hdma_active       controller DMA in progress
//   hdma_source_addr  byte source address
//   hdma_target_addr  byte target address (8000-9FFF)
//   vram_bank_sel     VBK bit 0, sampled with each request
//   mem_din           memory bus read data
//   mem_rd            memory read strobe
//   mem_addr          memory read address (holds when idle)
//   vram_we           one-cycle VRAM write strobe
//   vram_addr         target_addr[12:0] of the current write (holds when idle)
//   vram_bank         bank of the current write (holds when idle)
//   vram_dout         write data (holds when idle)
//   cpu_stall         hold the CPU
//   overflow          sticky; a request was lost, cleared by a rising
//                     edge of hdma_active

module hdma_xfer #(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hdma_rd,
    input  logic        hdma_active,
    input  logic [15:0] hdma_source_addr,
    input  logic [15:0] hdma_target_addr,
    input  logic        vram_bank_sel,
    input  logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic        vram_we,
    output logic [12:0] vram_addr,
    output logic        vram_bank,
    output logic [7:0]  vram_dout,
    output logic        cpu_stall,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR
    } state_t;

    // Value of the read-cycle counter on the edge that samples mem_din.
    localparam logic [1:0] RD_LAST = 2'(READ_LAT - 1);

    state_t      state_q;
    logic        rd_q;
    logic [15:0] src_q;
    logic        act_q;
    logic [1:0]  cnt_q;
    logic [12:0] cur_dst_q;
    logic        cur_bank_q;

    logic        pend_v_q;
    logic [15:0] pend_src_q;
    logic [12:0] pend_dst_q;
    logic        pend_bank_q;

    logic        mem_rd_q;
    logic [15:0] mem_addr_q;
    logic        vram_we_q;
    logic [12:0] vram_addr_q;
    logic        vram_bank_q;
    logic [7:0]  vram_dout_q;
    logic        ovf_q;

    logic        req;
    logic        req_acc;
    logic        req_to_pend;
    logic        req_drop;
    logic        launch_go;
    logic [15:0] launch_src;
    logic [12:0] launch_dst;
    logic        launch_bank;

    // Only the VRAM offset of the target address is used.
    logic        unused_tgt_hi;
    assign unused_tgt_hi = ^hdma_target_addr[15:13];

    // VRAM (8000-9FFF) and echo/OAM/IO/HRAM (E000-FFFF) are not DMA sources;
    // such bytes are written as FF without touching the memory bus.
    function automatic logic src_invalid(input logic [15:0] a);
        return (a[15:13] == 3'b100) || (a[15:13] == 3'b111);
    endfunction

    // A request is a rising read strobe or a source change while it is high.
    assign req     = hdma_rd & (~rd_q | (hdma_source_addr != src_q));
    assign req_acc = req & hdma_active;

    // Queue a request only while a read is in flight; any request that
    // meets a full slot (including the one being drained by WR) is lost.
    assign req_to_pend = req_acc && (state_q == S_RD) && !pend_v_q;
    assign req_drop    = req_acc && (state_q != S_IDLE) && pend_v_q;

    // Selects what, if anything, starts on this edge. A request arriving in
    // WR with an empty slot starts directly, which is equivalent to queueing
    // it and draining it on the same edge.
    always_comb begin
        launch_go   = 1'b0;
        launch_src  = hdma_source_addr;
        launch_dst  = hdma_target_addr[12:0];
        launch_bank = vram_bank_sel;
        case (state_q)
            S_IDLE: launch_go = req_acc;
            S_WR: begin
                if (pend_v_q && hdma_active) begin
                    launch_go   = 1'b1;
                    launch_src  = pend_src_q;
                    launch_dst  = pend_dst_q;
                    launch_bank = pend_bank_q;
                end else begin
                    launch_go = req_acc;
                end
            end
            default: launch_go = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_q        <= 1'b0;
            src_q       <= '0;
            act_q       <= 1'b0;
            cnt_q       <= '0;
            cur_dst_q   <= '0;
            cur_bank_q  <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_src_q  <= '0;
            pend_dst_q  <= '0;
            pend_bank_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            vram_we_q   <= 1'b0;
            vram_addr_q <= '0;
            vram_bank_q <= 1'b0;
            vram_dout_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            rd_q      <= hdma_rd;
            src_q     <= hdma_source_addr;
            act_q     <= hdma_active;
            vram_we_q <= 1'b0;

            if (hdma_active && !act_q) begin
                ovf_q <= 1'b0;
            end
            if (req_drop) begin
                ovf_q <= 1'b1;
            end

            if (req_to_pend) begin
                pend_v_q    <= 1'b1;
                pend_src_q  <= hdma_source_addr;
                pend_dst_q  <= hdma_target_addr[12:0];
                pend_bank_q <= vram_bank_sel;
            end

            case (state_q)
                S_IDLE, S_WR: begin
                    // WR always empties the slot: either it is launched now
                    // or the DMA was aborted and the queued byte is dropped.
                    if (state_q == S_WR) begin
                        pend_v_q <= 1'b0;
                    end
                    if (launch_go) begin
                        cur_dst_q  <= launch_dst;
                        cur_bank_q <= launch_bank;
                        if (src_invalid(launch_src)) begin
                            state_q     <= S_WR;
                            vram_we_q   <= 1'b1;
                            vram_addr_q <= launch_dst;
                            vram_bank_q <= launch_bank;
                            vram_dout_q <= 8'hFF;
                        end else begin
                            state_q    <= S_RD;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= launch_src;
                            cnt_q      <= '0;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RD: begin
                    if (cnt_q == RD_LAST) begin
                        state_q     <= S_WR;
                        mem_rd_q    <= 1'b0;
                        vram_we_q   <= 1'b1;
                        vram_addr_q <= cur_dst_q;
                        vram_bank_q <= cur_bank_q;
                        vram_dout_q <= mem_din;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign vram_we   = vram_we_q;
    assign vram_addr = vram_addr_q;
    assign vram_bank = vram_bank_q;
    assign vram_dout = vram_dout_q;
    assign overflow  = ovf_q;
    assign cpu_stall = hdma_active | (state_q != S_IDLE);

endmodule

// File: tb/tb_hdma_xfer.sv
// tb_hdma_xfer
//   Drives two hdma_xfer instances (READ_LAT=1 and READ_LAT=3) from shared
//   controller inputs. Each instance has its own memory model returning
//   address[7:0] ^ mem_xor. Outputs are sampled 1 time unit after the
//   rising edge; a negedge monitor logs every VRAM write and read cycle.

module tb_hdma_xfer;

    logic        clk = 1'b0;
    logic        reset;
    logic        hdma_rd;
    logic        hdma_active;
    logic [15:0] src;
    logic [15:0] dst;
    logic        bank_sel;
    logic [7:0]  mem_xor;

    logic        l1_mem_rd, l1_we, l1_vb, l1_stall, l1_ovf;
    logic [15:0] l1_maddr;
    logic [12:0] l1_va;
    logic [7:0]  l1_vd, l1_din;
    logic        l3_mem_rd, l3_we, l3_vb, l3_stall, l3_ovf;
    logic [15:0] l3_maddr;
    logic [12:0] l3_va;
    logic [7:0]  l3_vd, l3_din;

    always #5 clk = ~clk;

    assign l1_din = l1_maddr[7:0] ^ mem_xor;
    assign l3_din = l3_maddr[7:0] ^ mem_xor;

    hdma_xfer #(.READ_LAT(1)) u_l1 (
        .clk(clk), .reset(reset), .hdma_rd(hdma_rd), .hdma_active(hdma_active),
        .hdma_source_addr(src), .hdma_target_addr(dst), .vram_bank_sel(bank_sel),
        .mem_din(l1_din), .mem_rd(l1_mem_rd), .mem_addr(l1_maddr),
        .vram_we(l1_we), .vram_addr(l1_va), .vram_bank(l1_vb), .vram_dout(l1_vd),
        .cpu_stall(l1_stall), .overflow(l1_ovf)
    );

    hdma_xfer #(.READ_LAT(3)) u_l3 (
        .clk(clk), .reset(reset), .hdma_rd(hdma_rd), .hdma_active(hdma_active),
        .hdma_source_addr(src), .hdma_target_addr(dst), .vram_bank_sel(bank_sel),
        .mem_din(l3_din), .mem_rd(l3_mem_rd), .mem_addr(l3_maddr),
        .vram_we(l3_we), .vram_addr(l3_va), .vram_bank(l3_vb), .vram_dout(l3_vd),
        .cpu_stall(l3_stall), .overflow(l3_ovf)
    );

    // Write log entries are {bank, addr[12:0], data}.
    logic [21:0] wr_l1[$];
    logic [21:0] wr_l3[$];
    int          rdc_l1 = 0;
    int          rdc_l3 = 0;

    always @(negedge clk) begin
        if (l1_we) wr_l1.push_back({l1_vb, l1_va, l1_vd});
        if (l3_we) wr_l3.push_back({l3_vb, l3_va, l3_vd});
        if (l1_mem_rd) rdc_l1++;
        if (l3_mem_rd) rdc_l3++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        hdma_rd     = 1'b0;
        hdma_active = 1'b0;
        repeat (n) tick();
    endtask

    typedef struct {
        logic        rd;
        logic        act;
        logic [15:0] src;
        logic [15:0] dst;
        logic        bank;
        logic        mrd;
        logic [15:0] maddr;
        logic        we;
        logic [12:0] va;
        logic        vb;
        logic [7:0]  vd;
        logic        stall;
        logic        ovf;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic act, input logic [15:0] s,
                                input logic [15:0] d, input logic b, input logic mrd,
                                input logic [15:0] ma, input logic we, input logic [12:0] va,
                                input logic vb, input logic [7:0] vd, input logic st,
                                input logic ov);
        vec_t v;
        v.rd = rd; v.act = act; v.src = s; v.dst = d; v.bank = b;
        v.mrd = mrd; v.maddr = ma; v.we = we; v.va = va; v.vb = vb; v.vd = vd;
        v.stall = st; v.ovf = ov;
        return v;
    endfunction

    vec_t vt[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int b1, b3, r1, r3;
        logic [21:0] got;

        // Single byte C040->8200 bank 1 (data 40^1A=5A), then invalid
        // sources 8100/E000/9FFF and a back-to-back valid A000 (READ_LAT=1).
        vt[0]  = mk(0, 1, 16'hC040, 16'h8200, 1, 0, 16'h0000, 0, 13'h0000, 0, 8'h00, 1, 0);
        vt[1]  = mk(1, 1, 16'hC040, 16'h8200, 1, 1, 16'hC040, 0, 13'h0000, 0, 8'h00, 1, 0);
        vt[2]  = mk(0, 0, 16'hC040, 16'h8200, 1, 0, 16'hC040, 1, 13'h0200, 1, 8'h5A, 1, 0);
        vt[3]  = mk(0, 0, 16'hC040, 16'h8200, 1, 0, 16'hC040, 0, 13'h0200, 1, 8'h5A, 0, 0);
        vt[4]  = mk(0, 1, 16'h8100, 16'h8010, 0, 0, 16'hC040, 0, 13'h0200, 1, 8'h5A, 1, 0);
        vt[5]  = mk(1, 1, 16'h8100, 16'h8010, 0, 0, 16'hC040, 1, 13'h0010, 0, 8'hFF, 1, 0);
        vt[6]  = mk(0, 1, 16'hE000, 16'h8011, 1, 0, 16'hC040, 0, 13'h0010, 0, 8'hFF, 1, 0);
        vt[7]  = mk(1, 1, 16'hE000, 16'h8011, 1, 0, 16'hC040, 1, 13'h0011, 1, 8'hFF, 1, 0);
        vt[8]  = mk(1, 1, 16'hE000, 16'h8011, 1, 0, 16'hC040, 0, 13'h0011, 1, 8'hFF, 1, 0);
        vt[9]  = mk(1, 1, 16'h9FFF, 16'h9FFF, 0, 0, 16'hC040, 1, 13'h1FFF, 0, 8'hFF, 1, 0);
        vt[10] = mk(1, 1, 16'hA000, 16'h8001, 0, 1, 16'hA000, 0, 13'h1FFF, 0, 8'hFF, 1, 0);
        vt[11] = mk(1, 1, 16'hA000, 16'h8001, 0, 0, 16'hA000, 1, 13'h0001, 0, 8'h1A, 1, 0);
        vt[12] = mk(0, 0, 16'hA000, 16'h8001, 0, 0, 16'hA000, 0, 13'h0001, 0, 8'h1A, 0, 0);

        reset = 1'b1; hdma_rd = 1'b0; hdma_active = 1'b0;
        src = '0; dst = '0; bank_sel = 1'b0; mem_xor = 8'h1A;
        repeat (3) tick();
        chk("rst l1 outs", {l1_mem_rd, l1_maddr, l1_we, l1_va, l1_vb, l1_vd, l1_stall, l1_ovf}, '0);
        chk("rst l3 outs", {l3_mem_rd, l3_maddr, l3_we, l3_va, l3_vb, l3_vd, l3_stall, l3_ovf}, '0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            hdma_rd = vt[i].rd; hdma_active = vt[i].act;
            src = vt[i].src; dst = vt[i].dst; bank_sel = vt[i].bank;
            tick();
            chk($sformatf("v%0d mem_rd", i), l1_mem_rd, vt[i].mrd);
            chk($sformatf("v%0d mem_addr", i), l1_maddr, vt[i].maddr);
            chk($sformatf("v%0d vram_we", i), l1_we, vt[i].we);
            chk($sformatf("v%0d vram_addr", i), l1_va, vt[i].va);
            chk($sformatf("v%0d vram_bank", i), l1_vb, vt[i].vb);
            chk($sformatf("v%0d vram_dout", i), l1_vd, vt[i].vd);
            chk($sformatf("v%0d cpu_stall", i), l1_stall, vt[i].stall);
            chk($sformatf("v%0d overflow", i), l1_ovf, vt[i].ovf);
        end

        // 16-byte block, C000..C00F at 4-clock spacing, data = addr[7:0].
        idle(6);
        b1 = wr_l1.size(); b3 = wr_l3.size(); r1 = rdc_l1; r3 = rdc_l3;
        mem_xor = 8'h00; bank_sel = 1'b0;
        hdma_active = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            src = 16'hC000 + 16'(i); dst = 16'h8000 + 16'(i); hdma_rd = 1'b1;
            repeat (4) tick();
        end
        chk("blk l1 ovf", l1_ovf, 0);
        chk("blk l3 ovf", l3_ovf, 0);
        idle(8);
        chk("blk l1 count", wr_l1.size() - b1, 16);
        chk("blk l3 count", wr_l3.size() - b3, 16);
        chk("blk l1 reads", rdc_l1 - r1, 16);
        chk("blk l3 reads", rdc_l3 - r3, 48);
        for (int i = 0; i < 16; i++) begin
            got = (b1 + i < wr_l1.size()) ? wr_l1[b1 + i] : 22'h3FFFFF;
            chk($sformatf("blk l1 wr%0d", i), got, {1'b0, 13'(i), 8'(i)});
            got = (b3 + i < wr_l3.size()) ? wr_l3[b3 + i] : 22'h3FFFFF;
            chk($sformatf("blk l3 wr%0d", i), got, {1'b0, 13'(i), 8'(i)});
        end
        chk("blk l3 stall", l3_stall, 0);

        // READ_LAT=3, 2-clock spacing: second from pending, third overflows.
        idle(6);
        b3 = wr_l3.size(); r3 = rdc_l3;
        hdma_active = 1'b1;
        tick();
        chk("pend ovf start", l3_ovf, 0);
        src = 16'hD000; dst = 16'h8100; bank_sel = 1'b0; hdma_rd = 1'b1;
        tick();
        chk("pend rd1", {l3_mem_rd, l3_maddr}, {1'b1, 16'hD000});
        tick();
        src = 16'hD001; dst = 16'h8101;
        tick();
        chk("pend rd1 hold", {l3_mem_rd, l3_maddr, l3_ovf}, {1'b1, 16'hD000, 1'b0});
        tick();
        chk("pend wr1", {l3_we, l3_va, l3_vd}, {1'b1, 13'h0100, 8'h00});
        src = 16'hD002; dst = 16'h8102;
        tick();
        chk("pend ovf set", l3_ovf, 1);
        chk("pend rd2", {l3_mem_rd, l3_maddr, l3_we}, {1'b1, 16'hD001, 1'b0});
        repeat (2) tick();
        tick();
        chk("pend wr2", {l3_we, l3_va, l3_vd}, {1'b1, 13'h0101, 8'h01});
        tick();
        chk("pend idle", {l3_we, l3_mem_rd, l3_stall}, {1'b0, 1'b0, 1'b1});
        repeat (3) tick();
        chk("pend ovf sticky", l3_ovf, 1);
        hdma_rd = 1'b0; hdma_active = 1'b0;
        tick();
        chk("pend ovf fall", l3_ovf, 1);
        tick();
        hdma_active = 1'b1;
        tick();
        chk("pend ovf clear", l3_ovf, 0);
        idle(6);
        chk("pend wr count", wr_l3.size() - b3, 2);
        chk("pend reads", rdc_l3 - r3, 6);

        // Abort during RD with pending full.
        b3 = wr_l3.size(); r3 = rdc_l3;
        hdma_active = 1'b1;
        tick();
        src = 16'hD010; dst = 16'h8020; bank_sel = 1'b1; hdma_rd = 1'b1;
        tick();
        tick();
        src = 16'hD011; dst = 16'h8021;
        tick();
        hdma_active = 1'b0; hdma_rd = 1'b0;
        tick();
        chk("abort wr", {l3_we, l3_va, l3_vb, l3_vd, l3_stall}, {1'b1, 13'h0020, 1'b1, 8'h10, 1'b1});
        tick();
        chk("abort idle", {l3_we, l3_mem_rd, l3_stall}, {1'b0, 1'b0, 1'b0});
        idle(6);
        chk("abort wr count", wr_l3.size() - b3, 1);
        chk("abort reads", rdc_l3 - r3, 3);

        // Reset asserted during RD, then a normal transfer.
        hdma_active = 1'b1;
        tick();
        src = 16'hD020; dst = 16'h8030; bank_sel = 1'b1; hdma_rd = 1'b1;
        tick();
        chk("rst rd", l3_mem_rd, 1);
        tick();
        b3 = wr_l3.size();
        reset = 1'b1; hdma_active = 1'b0; hdma_rd = 1'b0;
        #1;
        chk("rst async outs", {l3_mem_rd, l3_maddr, l3_we, l3_va, l3_vb, l3_vd, l3_stall, l3_ovf}, '0);
        repeat (3) tick();
        chk("rst no write", wr_l3.size() - b3, 0);
        reset = 1'b0;
        tick();
        hdma_active = 1'b1;
        tick();
        src = 16'hD021; dst = 16'h8031; bank_sel = 1'b0; hdma_rd = 1'b1;
        tick();
        chk("rst re rd", {l3_mem_rd, l3_maddr}, {1'b1, 16'hD021});
        repeat (2) tick();
        chk("rst re rd3", l3_mem_rd, 1);
        tick();
        chk("rst re wr", {l3_we, l3_va, l3_vb, l3_vd, l3_mem_rd}, {1'b1, 13'h0031, 1'b0, 8'h21, 1'b0});
        tick();
        chk("rst re done", l3_we, 0);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
